fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage sitting directly upstream of the control unit. Holds the program counter, drives the instruction-memory address, and selects the next PC from PC+4 or a redirect target when the control unit asserts PCsrc. Registers the fetched word into an IF/ID pipeline register that feeds the decode stage. Supports stall and flush from the hazard logic, and halts on a misaligned redirect.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, bubble word (addi x0,x0,0) placed in IF/ID

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- stall  in  1  hold PC and IF/ID contents
- flush  in  1  replace IF/ID contents with bubble next edge
- PCsrc  in  1  redirect request (taken branch/jump), same encoding the control unit produces
- PCtarget  in  32  redirect address, valid when PCsrc=1
- imem_addr  out  32  current PC, to instruction memory
- imem_rdata  in  32  instruction word, combinational read of imem_addr
- instr_d  out  32  IF/ID instruction, to control unit / register file
- pc_d  out  32  IF/ID PC of instr_d
- pcplus4_d  out  32  IF/ID pc_d+4, used for jal/jalr link write
- valid_d  out  1  instr_d is a real fetched instruction (0 = bubble)
- trap  out  1  sticky misaligned-redirect flag
- fetch_count  out  32  count of valid instructions delivered to IF/ID

## Operation
- State machine, two states: RUN, HALT. Reset enters RUN.
- Reset values: PC=RESET_PC, instr_d=NOP_INSTR, pc_d=0, pcplus4_d=0, valid_d=0, trap=0, fetch_count=0.
- imem_addr = PC at all times (combinational from PC register).
- RUN, per edge, priority highest first:
  - PCsrc=1 and PCtarget[1:0]!=0: go HALT, trap=1, PC unchanged, IF/ID <- bubble.
  - PCsrc=1 (aligned): PC <- PCtarget, regardless of stall. IF/ID <- bubble (the word fetched this cycle is wrong-path).
  - flush=1: IF/ID <- bubble; PC <- PC+4 unless stall=1 (then PC held).
  - stall=1: PC and IF/ID held; fetch_count held.
  - otherwise: PC <- PC+4; instr_d <- imem_rdata, pc_d <- PC, pcplus4_d <- PC+4, valid_d <- 1.
- Bubble means instr_d=NOP_INSTR, valid_d=0, pc_d and pcplus4_d held at previous values.
- HALT: PC, trap held; IF/ID held as bubble; all inputs except rst ignored. Exit only via rst.
- fetch_count increments by 1 on every edge where valid_d is loaded as 1; wraps 2^32-1 -> 0.
- Arithmetic: PC+4 is 32-bit modulo; PC=32'hFFFF_FFFC advances to 0 with no flag.
- Misalignment is checked only on redirects; RESET_PC is required to be word-aligned.

## Timing
- Fetch latency: 1 cycle. Word at PC appears on instr_d the edge after PC is presented.
- Redirect: PCsrc sampled at edge N; imem_addr=PCtarget after edge N; target instruction on instr_d after edge N+1; exactly one bubble between.
- Stall is level-sensitive; n cycles of stall hold outputs for exactly n cycles.
- rst asserted mid-operation (including in HALT or while stalled) overrides everything at that edge; first real instruction appears on instr_d two edges after rst deasserts sampling.
- PCsrc and flush same cycle: redirect applies to PC, IF/ID gets one bubble (not two).
- trap rises at the edge that samples the misaligned redirect and stays high until rst.

## Test plan
- Reset then free-run, imem returning word=addr: instr_d sequence 0x0,0x4,0x8 from the second edge after reset; valid_d=1, pcplus4_d=pc_d+4; fetch_count=3 after three valid loads.
- Stall 3 cycles at PC=0x8: imem_addr stays 0x8, instr_d stays 0x4 for 3 cycles, fetch_count unchanged, then resumes 0x8,0xC.
- PCsrc=1, PCtarget=0x100 while PC=0x10: next imem_addr=0x100, instr_d=0x00000013 with valid_d=0 for one cycle, then 0x100.
- PCsrc=1, PCtarget=0x102: trap=1, imem_addr frozen at current PC, valid_d=0 indefinitely; later rst clears trap and PC=RESET_PC.
- Simultaneous stall+flush at PC=0x20: PC held 0x20, one bubble in IF/ID; simultaneous stall+PCsrc to 0x40: PC=0x40.
- Wrap: force redirect to 0xFFFFFFFC, run 2 cycles: imem_addr 0xFFFFFFFC then 0x0, pcplus4_d=0x0 for the 0xFFFFFFFC instruction, trap=0.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage feeding the decode stage.
// Holds the PC, presents it to instruction memory, and registers the
// returned word into the IF/ID pipeline register. A redirect (PCsrc) wins
// over flush, and flush wins over stall. A misaligned redirect halts the
// stage with a sticky trap until reset.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   stall        hold PC and IF/ID
//   flush        load a bubble into IF/ID
//   PCsrc        redirect request
//   PCtarget     redirect address
//   imem_addr    current PC to instruction memory
//   imem_rdata   instruction word read combinationally at imem_addr
//   instr_d      IF/ID instruction
//   pc_d         IF/ID PC
//   pcplus4_d    IF/ID PC+4 (link value)
//   valid_d      IF/ID holds a real instruction (0 = bubble)
//   trap         sticky misaligned-redirect flag
//   fetch_count  number of valid instructions loaded into IF/ID
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        PCsrc,
  input  logic [31:0] PCtarget,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d,
  output logic        trap,
  output logic [31:0] fetch_count
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misaligned;

  assign imem_addr  = pc;
  assign pc_plus4   = pc + 32'd4;
  assign misaligned = PCtarget[1:0] != 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      instr_d     <= NOP_INSTR;
      pc_d        <= '0;
      pcplus4_d   <= '0;
      valid_d     <= 1'b0;
      trap        <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        RUN: begin
          if (PCsrc && misaligned) begin
            // PC stays at the last good address so the faulting fetch point
            // remains observable on imem_addr.
            state   <= HALT;
            trap    <= 1'b1;
            instr_d <= NOP_INSTR;
            valid_d <= 1'b0;
          end else if (PCsrc) begin
            // Redirect overrides stall; the word fetched this cycle is
            // wrong-path, so IF/ID takes a single bubble even if flush is set.
            pc      <= PCtarget;
            instr_d <= NOP_INSTR;
            valid_d <= 1'b0;
          end else if (flush) begin
            instr_d <= NOP_INSTR;
            valid_d <= 1'b0;
            if (!stall) begin
              pc <= pc_plus4;
            end
          end else if (!stall) begin
            pc          <= pc_plus4;
            instr_d     <= imem_rdata;
            pc_d        <= pc;
            pcplus4_d   <= pc_plus4;
            valid_d     <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
          end
        end
        HALT: begin
          // IF/ID was already loaded with a bubble on entry; only rst leaves.
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized scoreboard bench for fetch_stage.
// A reference model of the fetch rules pushes the expected post-edge outputs
// into a queue at every rising edge; an independent monitor pops and compares
// them against the DUT shortly after the edge. Instruction memory returns
// addr ^ key, where key is changed by the stimulus.
module tb_fetch_stage;

  localparam logic [31:0] RP  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        PCsrc;
  logic [31:0] PCtarget;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pcplus4_d;
  logic        valid_d;
  logic        trap;
  logic [31:0] fetch_count;
  logic [31:0] key;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ key;

  fetch_stage #(.RESET_PC(RP), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .PCsrc(PCsrc), .PCtarget(PCtarget),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_d(instr_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d),
    .valid_d(valid_d), .trap(trap), .fetch_count(fetch_count)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] p4;
    logic [31:0] count;
    logic        valid;
    logic        trap;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: architectural view of the stage.
  logic [31:0] m_pc, m_instr, m_pcd, m_p4d, m_count;
  logic        m_valid, m_trap, m_halted;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_pc = RP; m_instr = NOP; m_pcd = 0; m_p4d = 0;
        m_valid = 0; m_trap = 0; m_halted = 0; m_count = 0;
      end else if (!m_halted) begin
        if (PCsrc && (PCtarget % 4 != 0)) begin
          m_halted = 1; m_trap = 1; m_instr = NOP; m_valid = 0;
        end else if (PCsrc) begin
          m_pc = PCtarget; m_instr = NOP; m_valid = 0;
        end else if (flush) begin
          m_instr = NOP; m_valid = 0;
          if (!stall) m_pc = m_pc + 4;
        end else if (!stall) begin
          m_instr = m_pc ^ key;
          m_pcd   = m_pc;
          m_p4d   = m_pc + 4;
          m_valid = 1;
          m_count = m_count + 1;
          m_pc    = m_pc + 4;
        end
      end
      q.push_back('{addr: m_pc, instr: m_instr, pc: m_pcd, p4: m_p4d,
                    count: m_count, valid: m_valid, trap: m_trap});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected vector per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
      end else begin
        e = q.pop_front();
        vectors++;
        chk("imem_addr",   imem_addr,   e.addr);
        chk("instr_d",     instr_d,     e.instr);
        chk("pc_d",        pc_d,        e.pc);
        chk("pcplus4_d",   pcplus4_d,   e.p4);
        chk("fetch_count", fetch_count, e.count);
        chk("valid_d",     {31'd0, valid_d}, {31'd0, e.valid});
        chk("trap",        {31'd0, trap},    {31'd0, e.trap});
      end
    end
  end

  task automatic drive(input logic s, input logic f, input logic p,
                       input logic [31:0] t, input logic r);
    @(negedge clk);
    stall = s; flush = f; PCsrc = p; PCtarget = t; rst = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 32'h0, 0);
  endtask

  initial begin
    logic [31:0] t;
    rst = 1; stall = 0; flush = 0; PCsrc = 0; PCtarget = 0; key = 0;
    repeat (2) @(posedge clk);

    // Free-run from reset: instr 0x0, 0x4; PC now 0x8.
    idle(2);
    // Stall three cycles at PC=0x8.
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 32'h0, 0);
    idle(2);                                  // instr 0x8, 0xC; PC=0x10
    drive(0, 0, 1, 32'h100, 0);               // redirect
    idle(3);
    drive(1, 1, 0, 32'h0, 0);                 // stall+flush: PC held, one bubble
    idle(2);
    drive(1, 0, 1, 32'h40, 0);                // stall+redirect: PC=0x40
    idle(2);
    drive(0, 1, 1, 32'h80, 0);                // redirect+flush: single bubble
    idle(2);
    drive(0, 0, 1, 32'hFFFF_FFFC, 0);         // wrap
    idle(3);
    drive(0, 0, 1, 32'h102, 0);               // misaligned -> halt
    for (int i = 0; i < 4; i++)
      drive(1'($urandom), 1'($urandom), 1'($urandom), $urandom, 0);
    drive(0, 0, 0, 32'h0, 1);                 // reset out of halt
    idle(3);
    drive(1, 0, 0, 32'h0, 0);
    drive(1, 0, 0, 32'h0, 1);                 // reset while stalled
    idle(3);

    // Randomized phase.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) key = $urandom;
      t = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | (t & 32'hC);
      if ($urandom_range(0, 29) == 0) t[1:0] = 2'($urandom_range(1, 3));
      drive($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0, t, $urandom_range(0, 99) == 0);
    end

    idle(2);
    @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
